// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian words into 512-bit blocks, appends the
// 0x80 marker and 64-bit bit length, and streams each block to the hash core.
module sha256_padder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        core_rst,
    output logic        core_soc,
    output logic [31:0] core_data,
    input  logic        core_eoc,
    output logic        msg_done
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, HOLD, CRST, CSOC, SEND, FINW} state_t;

    state_t      state, state_n;
    logic [31:0] blk_buf [16];
    logic [3:0]  idx;
    logic [31:0] bytes;
    logic        first_blk, final_blk, need_extra, core_busy;
    logic        eoc_armed;  // last SEND word has gone out; core_eoc may now end the block
    logic        mark_pend;  // full last word: 0x80000000 still owed at the next free index
    logic        len_ok;     // 0x80 marker sits at index <= 13, so the length fits here

    logic        xfer;
    logic [2:0]  nb;
    logic [5:0]  sh;
    logic [31:0] in_word;
    logic        pad_len;
    logic [31:0] pad_word;

    assign xfer = in_valid & in_ready;
    assign nb   = (!in_last || in_nbytes >= 3'd4) ? 3'd4 : in_nbytes;
    assign sh   = {nb, 3'b000};
    // Keep the valid bytes, drop the marker right below them; for nb=4 both terms vanish.
    assign in_word = (in_data & ~(32'hFFFF_FFFF >> sh)) | (32'h8000_0000 >> sh);

    assign pad_len = mark_pend ? (idx <= 4'd13) : len_ok;
    always_comb begin
        pad_word = 32'h0;
        if (mark_pend)                    pad_word = 32'h8000_0000;
        else if (pad_len && idx == 4'd14) pad_word = {29'b0, bytes[31:29]};
        else if (pad_len && idx == 4'd15) pad_word = {bytes[28:0], 3'b000};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = (state == IDLE) || (state == FILL);
        core_rst  = (state == CRST);
        core_soc  = (state == CSOC);
        core_data = (state == SEND) ? blk_buf[idx] : 32'h0;
        msg_done  = (state == FINW) && !core_busy;
        case (state)
            IDLE: if (xfer) state_n = in_last ? PAD : FILL;
            FILL: if (xfer) begin
                if (idx == 4'd15) state_n = HOLD;
                else if (in_last) state_n = PAD;
            end
            PAD:  if (idx == 4'd15) state_n = HOLD;
            HOLD: if (!core_busy) state_n = first_blk ? CRST : CSOC;
            CRST: state_n = CSOC;
            CSOC: state_n = SEND;
            SEND: if (idx == 4'd15) begin
                if (need_extra)     state_n = PAD;
                else if (final_blk) state_n = FINW;
                else                state_n = FILL;
            end
            FINW: if (!core_busy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: the block buffer is deliberately left out of reset; every word is rewritten
    // before it is sent, so a reset mux on 512 flops would buy nothing.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (xfer) blk_buf[0] <= in_word;
            FILL: if (xfer) blk_buf[idx] <= in_word;
            PAD:  blk_buf[idx] <= pad_word;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 4'd0;
            bytes      <= 32'd0;
            first_blk  <= 1'b0;
            final_blk  <= 1'b0;
            need_extra <= 1'b0;
            core_busy  <= 1'b0;
            eoc_armed  <= 1'b0;
            mark_pend  <= 1'b0;
            len_ok     <= 1'b0;
        end else begin
            if (core_busy && eoc_armed && core_eoc) begin
                core_busy <= 1'b0;
                eoc_armed <= 1'b0;
            end
            case (state)
                IDLE: if (xfer) begin
                    first_blk  <= 1'b1;
                    final_blk  <= 1'b0;
                    need_extra <= 1'b0;
                    mark_pend  <= in_last && (nb == 3'd4);
                    len_ok     <= 1'b1;
                    bytes      <= {29'b0, nb};
                    idx        <= 4'd1;
                end
                FILL: if (xfer) begin
                    bytes <= bytes + {29'b0, nb};
                    idx   <= idx + 4'd1;
                    if (in_last) begin
                        mark_pend <= (nb == 3'd4);
                        len_ok    <= (idx <= 4'd13);
                        if (idx == 4'd15) need_extra <= 1'b1;
                    end
                end
                PAD: begin
                    mark_pend <= 1'b0;
                    len_ok    <= pad_len;
                    idx       <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        if (pad_len) final_blk  <= 1'b1;
                        else         need_extra <= 1'b1;
                    end
                end
                CRST: first_blk <= 1'b0;
                CSOC: begin
                    core_busy <= 1'b1;
                    idx       <= 4'd0;
                end
                SEND: begin
                    idx <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        eoc_armed <= 1'b1;
                        if (need_extra) begin
                            need_extra <= 1'b0;
                            len_ok     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
